crc24_attach: RTL and testbench

CRC24_ATTACH -- requirements
Module: crc24_attach

---
 rtl/crc24_attach.sv | 119 +++++++++++
 tb/tb_crc24_attach.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/crc24_attach.sv
// crc24_attach
// Serial CRC24A attachment for 1056-bit (1032 payload) or 6144-bit
// (6120 payload) coded blocks. Payload bits are echoed one cycle after
// acceptance. The 24 CRC bits follow immediately, MSB first.
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous, active-high
//   block_size   : 0 = 1032-bit payload, 1 = 6120-bit payload (sampled at blk_start)
//   blk_start    : frame request, honoured only in IDLE
//   in_valid     : in_data carries a payload bit
//   in_data      : payload bit, first-transmitted first
//   in_ready     : payload bit accepted when in_valid && in_ready
//   CRC_start    : pulse with the first output bit of a frame
//   CRC_data     : serial output (payload, then CRC); 0 when out_valid=0
//   out_valid    : CRC_data valid
//   CRC_END      : pulse with the last CRC bit
//   block_size_o : block_size latched at frame start
//   busy         : high whenever not IDLE
module crc24_attach (
    input  logic clk,
    input  logic reset,
    input  logic block_size,
    input  logic blk_start,
    input  logic in_valid,
    input  logic in_data,
    output logic in_ready,
    output logic CRC_start,
    output logic CRC_data,
    output logic out_valid,
    output logic CRC_END,
    output logic block_size_o,
    output logic busy
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, DONE} state_t;

    localparam logic [23:0] POLY = 24'h864CFB;

    state_t      state, state_nxt;
    logic [12:0] pay_cnt;
    logic [4:0]  par_cnt;
    logic [23:0] crc;
    logic        accept;
    logic        last_bit;
    logic        fb;

    assign accept   = (state == DATA) && in_valid;
    assign last_bit = block_size_o ? (pay_cnt == 13'd6119) : (pay_cnt == 13'd1031);
    assign fb       = crc[23] ^ in_data;
    assign in_ready = (state == DATA);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (blk_start) state_nxt = DATA;
            DATA:    if (accept && last_bit) state_nxt = PARITY;
            PARITY:  if (par_cnt == 5'd23) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so the last payload bit is on the wire during
    // the first PARITY cycle and the last CRC bit during DONE; this keeps
    // payload and CRC contiguous with no idle slot between them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pay_cnt      <= '0;
            par_cnt      <= '0;
            crc          <= '0;
            block_size_o <= 1'b0;
            out_valid    <= 1'b0;
            CRC_data     <= 1'b0;
            CRC_start    <= 1'b0;
            CRC_END      <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            CRC_data  <= 1'b0;
            CRC_start <= 1'b0;
            CRC_END   <= 1'b0;
            case (state)
                IDLE: begin
                    if (blk_start) begin
                        block_size_o <= block_size;
                        pay_cnt      <= '0;
                        par_cnt      <= '0;
                        crc          <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        pay_cnt   <= pay_cnt + 13'd1;
                        crc       <= {crc[22:0], 1'b0} ^ (fb ? POLY : '0);
                        out_valid <= 1'b1;
                        CRC_data  <= in_data;
                        CRC_start <= (pay_cnt == 13'd0);
                    end
                end
                PARITY: begin
                    // Shift the frozen remainder out MSB first.
                    out_valid <= 1'b1;
                    CRC_data  <= crc[23];
                    crc       <= {crc[22:0], 1'b0};
                    par_cnt   <= par_cnt + 5'd1;
                    CRC_END   <= (par_cnt == 5'd23);
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc24_attach.sv
// Testbench for crc24_attach: randomized frames, scoreboard queue filled by
// the stimulus side and drained by an independent output monitor. The CRC
// reference is polynomial long division over the whole message.
module tb_crc24_attach;

    logic clk = 1'b0;
    logic reset, block_size, blk_start, in_valid, in_data;
    logic in_ready, CRC_start, CRC_data, out_valid, CRC_END, block_size_o, busy;

    crc24_attach dut (
        .clk(clk), .reset(reset), .block_size(block_size), .blk_start(blk_start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .CRC_start(CRC_start), .CRC_data(CRC_data), .out_valid(out_valid),
        .CRC_END(CRC_END), .block_size_o(block_size_o), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit d;
        bit s;
        bit e;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   exp_bs = 1'b0;
    int   out_cnt = 0;

    task automatic chk(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // CRC as the remainder of M(x)*x^24 divided by the generator.
    function automatic logic [23:0] crc_model(input bit msg[$]);
        bit          m[$];
        logic [24:0] g;
        logic [23:0] r;
        int          n;
        g = 25'h1864CFB;
        m = msg;
        n = msg.size();
        for (int k = 0; k < 24; k++) m.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (m[i])
                for (int j = 0; j < 25; j++) m[i+j] = m[i+j] ^ g[24-j];
        for (int k = 0; k < 24; k++) r[23-k] = m[n+k];
        return r;
    endfunction

    // Output monitor: independent of the stimulus process.
    always @(negedge clk) begin
        if (reset) begin
            out_cnt = 0;
        end else if (out_valid) begin
            exp_t e;
            out_cnt = CRC_start ? 1 : out_cnt + 1;
            chk("block_size_o", block_size_o == exp_bs, block_size_o, exp_bs);
            if (sbq.size() == 0) begin
                chk("unexpected_output", 1'b0, 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("CRC_data", CRC_data == e.d, CRC_data, e.d);
                chk("CRC_start", CRC_start == e.s, CRC_start, e.s);
                chk("CRC_END", CRC_END == e.e, CRC_END, e.e);
            end
            if (CRC_END)
                chk("frame_length", out_cnt == (exp_bs ? 6144 : 1056), out_cnt, exp_bs ? 6144 : 1056);
        end else begin
            chk("idle_outputs", {CRC_data, CRC_start, CRC_END} == 3'b000,
                {CRC_data, CRC_start, CRC_END}, 0);
        end
    end

    // Caller is positioned just after a rising edge with the DUT in IDLE.
    task automatic run_frame(input bit bs, input bit bits[$], input int gap_pct,
                             input int abort_after, input bit disturb);
        int n, idx, budget;
        bit acc;
        logic [23:0] c;
        n = bits.size();
        block_size = bs;
        blk_start  = 1'b1;
        in_valid   = 1'b1;       // ignored: in_ready is low in IDLE
        in_data    = 1'($urandom);
        exp_bs     = bs;
        @(posedge clk); #1;
        blk_start  = 1'b0;
        block_size = 1'($urandom);
        idx = 0;
        budget = 0;
        while (idx < n && budget < 20000 && !(abort_after >= 0 && idx >= abort_after)) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? bits[idx] : 1'($urandom);
            blk_start = 1'b0;
            if (disturb && (idx == 100 || idx == 3000)) begin
                blk_start  = 1'b1;
                block_size = ~bs;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sbq.push_back('{d: bits[idx], s: (idx == 0), e: 1'b0});
                idx++;
            end
            budget++;
        end
        in_valid  = 1'b0;
        blk_start = 1'b0;
        if (abort_after < 0) begin
            chk("payload_accept_timeout", idx == n, idx, n);
            c = crc_model(bits);
            for (int k = 23; k >= 0; k--)
                sbq.push_back('{d: c[k], s: 1'b0, e: (k == 0)});
        end
    endtask

    // Wait until CRC_END is visible (DONE cycle); leaves caller at a negedge.
    task automatic wait_end();
        int t;
        t = 0;
        while (t < 200) begin
            @(negedge clk);
            if (CRC_END) break;
            t++;
        end
        chk("crc_end_timeout", t < 200, t, 200);
    endtask

    task automatic drain_to_idle();
        wait_end();
        @(posedge clk); #1;
        chk("scoreboard_empty", sbq.size() == 0, sbq.size(), 0);
        chk("busy_after_frame", busy == 1'b0, busy, 0);
    endtask

    bit frame[$];

    initial begin
        reset = 1'b1; block_size = 1'b0; blk_start = 1'b0; in_valid = 1'b0; in_data = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready == 1'b0, in_ready, 0);
        chk("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        chk("rst_busy", busy == 1'b0, busy, 0);
        chk("rst_block_size_o", block_size_o == 1'b0, block_size_o, 0);
        chk("rst_strobes", {CRC_data, CRC_start, CRC_END} == 3'b000, {CRC_data, CRC_start, CRC_END}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // All-zero short frame, continuous input.
        frame.delete();
        for (int i = 0; i < 1032; i++) frame.push_back(1'b0);
        run_frame(1'b0, frame, 0, -1, 1'b0);
        drain_to_idle();

        // Single trailing one: remainder equals the generator low bits.
        frame.delete();
        for (int i = 0; i < 1031; i++) frame.push_back(1'b0);
        frame.push_back(1'b1);
        run_frame(1'b0, frame, 0, -1, 1'b0);
        drain_to_idle();

        // Long frame, random data and gaps, mid-frame blk_start/block_size noise.
        frame.delete();
        for (int i = 0; i < 6120; i++) frame.push_back(1'($urandom));
        run_frame(1'b1, frame, 30, -1, 1'b1);
        chk("block_size_o_held", block_size_o == 1'b1, block_size_o, 1);
        drain_to_idle();

        // Reset after 500 accepted bits.
        frame.delete();
        for (int i = 0; i < 6120; i++) frame.push_back(1'($urandom));
        run_frame(1'b1, frame, 20, 500, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk("abort_out_valid", out_valid == 1'b0, out_valid, 0);
        chk("abort_busy", busy == 1'b0, busy, 0);
        chk("abort_in_ready", in_ready == 1'b0, in_ready, 0);
        chk("abort_block_size_o", block_size_o == 1'b0, block_size_o, 0);
        repeat (5) begin
            @(negedge clk);
            chk("abort_silent", out_valid == 1'b0, out_valid, 0);
        end
        @(posedge clk); #1;
        frame.delete();
        for (int i = 0; i < 1031; i++) frame.push_back(1'b0);
        frame.push_back(1'b1);
        run_frame(1'b0, frame, 10, -1, 1'b0);

        // Back-to-back: blk_start in DONE ignored, next IDLE cycle honoured.
        wait_end();
        blk_start  = 1'b1;
        block_size = 1'b1;
        @(posedge clk); #1;
        blk_start = 1'b0;
        chk("done_blk_start_ignored", busy == 1'b0, busy, 0);
        chk("done_bso_unchanged", block_size_o == 1'b0, block_size_o, 0);
        frame.delete();
        for (int i = 0; i < 1032; i++) frame.push_back(1'($urandom));
        run_frame(1'b0, frame, 15, -1, 1'b0);
        drain_to_idle();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
